// File: rtl/frac_clken_gen.sv
// Fractional clock-enable generator: per-channel phase accumulators whose carry-outs
// form ce pulses, retuned glitch-free through a single-entry configuration shadow.
module frac_clken_gen #(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_PULSES = 4,
  parameter logic [CHANNELS*ACC_W-1:0] INC_RST = {CHANNELS{1'b1, {(ACC_W-1){1'b0}}}}
) (
  input  logic                                           clk_sys,
  input  logic                                           rst_n,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                               cfg_inc,
  input  logic [ACC_W-1:0]                               cfg_phase,
  output logic [CHANNELS-1:0]                            ce,
  output logic                                           locked
);

  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0]  CNT_MAX = '1;

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_t;

  cfg_state_t          cfg_state;
  logic [CH_W-1:0]     sh_ch;
  logic [ACC_W-1:0]    sh_inc;
  logic [ACC_W-1:0]    sh_phase;

  logic [ACC_W-1:0]    acc       [CHANNELS];
  logic [ACC_W-1:0]    inc       [CHANNELS];
  logic [7:0]          pulse_cnt [CHANNELS];
  logic [ACC_W-1:0]    sum       [CHANNELS];

  logic [CHANNELS-1:0] carry;
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] apply;
  logic                accept;
  logic                ch_valid;
  logic                cnt_ok;
  logic                lock_cond;

  assign cfg_ready = (cfg_state == CFG_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign ch_valid  = (32'(cfg_ch) < CHANNELS);

  // A zero increment never carries, so inactive channels hold acc and keep ce low
  // without any special-casing.
  always_comb begin
    carry  = '0;
    active = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      {carry[i], sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
      active[i]          = (inc[i] != '0);
    end
  end

  // Active targets retune on their own carry so the boundary pulse is kept;
  // inactive targets have no carry to wait for and retune immediately.
  always_comb begin
    apply = '0;
    if (cfg_state == CFG_PEND) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sh_ch == CH_W'(i)) begin
          apply[i] = active[i] ? carry[i] : 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_ok = 1'b1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (active[i] && (32'(pulse_cnt[i]) < LOCK_PULSES)) begin
        cnt_ok = 1'b0;
      end
    end
    lock_cond = cfg_ready && !accept && (|active) && cnt_ok;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cfg_state <= CFG_IDLE;
      sh_ch     <= '0;
      sh_inc    <= '0;
      sh_phase  <= '0;
      ce        <= '0;
      locked    <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc[i]       <= '0;
        inc[i]       <= INC_RST[i*ACC_W +: ACC_W];
        pulse_cnt[i] <= '0;
      end
    end else begin
      ce     <= carry;
      locked <= lock_cond;

      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (apply[i]) begin
          acc[i]       <= sh_phase;
          inc[i]       <= sh_inc;
          pulse_cnt[i] <= '0;
        end else begin
          acc[i] <= sum[i];
          if (carry[i] && (pulse_cnt[i] != CNT_MAX)) begin
            pulse_cnt[i] <= pulse_cnt[i] + 8'd1;
          end
        end
      end

      // Out-of-range channels complete the handshake but never reach the shadow.
      case (cfg_state)
        CFG_IDLE: begin
          if (accept && ch_valid) begin
            sh_ch     <= cfg_ch;
            sh_inc    <= cfg_inc;
            sh_phase  <= cfg_phase;
            cfg_state <= CFG_PEND;
          end
        end
        CFG_PEND: begin
          if (|apply) begin
            cfg_state <= CFG_IDLE;
          end
        end
        default: cfg_state <= CFG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Testbench for frac_clken_gen: scenario tasks plus randomized traffic, all checked
// against a cycle-level arithmetic model of the accumulators and config handshake.
module tb_frac_clken_gen;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [31:0] cfg_phase;
  logic [2:0]  ce;
  logic        locked;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // reference model state
  longint unsigned m_acc [3];
  longint unsigned m_inc [3];
  int              m_cnt [3];
  logic [2:0]      m_ce;
  bit              m_locked;
  bit              m_pend;
  int              m_sch;
  longint unsigned m_sinc;
  longint unsigned m_sph;

  frac_clken_gen #(
    .CHANNELS   (3),
    .ACC_W      (32),
    .LOCK_PULSES(4)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .ce       (ce),
    .locked   (locked)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    bit acc_ok, pend_nx, all_ok, any_act, c;
    longint unsigned s;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_acc[i] = 0;
        m_inc[i] = 64'h8000_0000;
        m_cnt[i] = 0;
      end
      m_ce = '0; m_locked = 0; m_pend = 0;
    end else begin
      acc_ok  = cfg_valid && !m_pend;
      any_act = 0;
      all_ok  = 1;
      for (int i = 0; i < 3; i++) begin
        if (m_inc[i] != 0) begin
          any_act = 1;
          if (m_cnt[i] < 4) all_ok = 0;
        end
      end
      m_locked = !m_pend && !acc_ok && any_act && all_ok;
      pend_nx  = m_pend;
      for (int i = 0; i < 3; i++) begin
        s       = m_acc[i] + m_inc[i];
        c       = (s >= MOD);
        m_ce[i] = c;
        if (m_pend && m_sch == i && (m_inc[i] == 0 || c)) begin
          m_acc[i] = m_sph;
          m_inc[i] = m_sinc;
          m_cnt[i] = 0;
          pend_nx  = 0;
        end else begin
          m_acc[i] = s % MOD;
          if (c && m_cnt[i] < 255) m_cnt[i]++;
        end
      end
      if (acc_ok && cfg_ch < 3) begin
        pend_nx = 1;
        m_sch   = int'(cfg_ch);
        m_sinc  = cfg_inc;
        m_sph   = cfg_phase;
      end
      m_pend = pend_nx;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] ch, input logic [31:0] inc, input logic [31:0] ph,
                      output bit ok);
    cfg_ch = ch; cfg_inc = inc; cfg_phase = ph; cfg_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      ok = cfg_ready;
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
    repeat (3) tick();
    vectors++;
    if ({ce, locked, cfg_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_state: ce=%b locked=%b ready=%b, required ce=000 locked=0 ready=1",
               ce, locked, cfg_ready);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (ce[0] !== ((k % 2) == 0)) begin
        miscompares++;
        $display("FAIL rst_ce0_pattern edge %0d: ce0=%b required %b", k, ce[0], (k % 2) == 0);
      end
      vectors++;
      if (locked !== (k >= 9)) begin
        miscompares++;
        $display("FAIL rst_lock edge %0d: locked=%b required %b", k, locked, k >= 9);
      end
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL reset_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
  endtask

  task automatic test_fractional();
    bit ok;
    int count = 0;
    send(2'd1, 32'h2AAA_AAAB, 32'h0, ok);
    vectors++;
    if (!ok || locked !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL frac_accept: ok=%b locked=%b ready=%b, required 1 0 0", ok, locked, cfg_ready);
    end
    for (int n = 0; n < 20 && !cfg_ready; n++) tick();
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL frac_apply_timeout: ready=%b required 1", cfg_ready);
    end
    for (int n = 0; n < 6000; n++) begin
      tick();
      count += int'(ce[1]);
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL frac_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
    vectors++;
    if (count < 999 || count > 1001) begin
      miscompares++;
      $display("FAIL frac_rate: %0d pulses in 6000 cycles, required 1000 +/-1", count);
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL frac_relock: locked=%b required 1", locked);
    end
  endtask

  task automatic test_boundary();
    bit ok, acc_now;
    int ta = -1;
    int j  = -1;
    int pulses[$];
    int gap_exp[4] = '{4, 1, 2, 2};
    send(2'd0, 32'h4000_0000, 32'h0, ok);
    for (int n = 0; n < 20 && !cfg_ready; n++) tick();
    repeat (10) tick();
    for (int k = 0; k < 30; k++) begin
      if (k == 8) begin
        cfg_ch = 2'd0; cfg_inc = 32'h8000_0000; cfg_phase = 32'h8000_0000; cfg_valid = 1'b1;
      end
      acc_now = cfg_valid && cfg_ready;
      tick();
      if (acc_now) begin ta = cyc; cfg_valid = 1'b0; end
      if (ce[0]) pulses.push_back(cyc);
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL boundary_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
    for (int p = 0; p < pulses.size() && j < 0; p++) if (ta >= 0 && pulses[p] > ta) j = p;
    for (int g = 0; g < 4; g++) begin
      vectors++;
      if (j < 1 || j + 3 >= pulses.size()) begin
        miscompares++;
        $display("FAIL boundary_gap%0d: apply pulse index %0d of %0d pulses, required a full sequence",
                 g, j, pulses.size());
      end else if (pulses[j+g] - pulses[j+g-1] != gap_exp[g]) begin
        miscompares++;
        $display("FAIL boundary_gap%0d: gap=%0d required %0d", g,
                 pulses[j+g] - pulses[j+g-1], gap_exp[g]);
      end
    end
  endtask

  task automatic test_inactive();
    bit ok;
    send(2'd2, 32'h0, 32'h0, ok);
    for (int n = 0; n < 20 && !cfg_ready; n++) tick();
    for (int n = 0; n < 200 && !locked; n++) begin
      tick();
      vectors++;
      if (ce[2] !== 1'b0 || {ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL inactive_hold cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL inactive_relock: locked=%b required 1", locked);
    end
    send(2'd2, 32'h8000_0000, 32'h0, ok);
    vectors++;
    if (!ok || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL inactive_accept: ok=%b ready=%b required 1 0", ok, cfg_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (cfg_ready !== 1'b1 || ce[2] !== (k == 3)) begin
        miscompares++;
        $display("FAIL inactive_apply +%0d: ready=%b ce2=%b required 1 %b", k, cfg_ready,
                 ce[2], k == 3);
      end
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL inactive_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
  endtask

  task automatic test_handshake();
    bit ok;
    send(2'd1, 32'h0100_0000, 32'h0, ok);
    for (int n = 0; n < 20 && !cfg_ready; n++) tick();
    send(2'd1, 32'h2AAA_AAAB, 32'h0, ok);
    for (int k = 0; k < 10; k++) begin
      cfg_valid = 1'b1;
      cfg_ch    = 2'($urandom_range(0, 2));
      cfg_inc   = $urandom;
      cfg_phase = $urandom;
      tick();
      vectors++;
      if (cfg_ready !== 1'b0 || {ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL hs_hold cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
    cfg_valid = 1'b0;
    for (int n = 0; n < 300 && !cfg_ready; n++) tick();
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_apply_timeout: ready=%b required 1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = $urandom; cfg_phase = $urandom;
    tick();
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_discard_ready: ready=%b required 1", cfg_ready);
    end
    repeat (20) begin
      tick();
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL hs_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
  endtask

  task automatic test_reset_pending();
    bit ok;
    send(2'd0, 32'h4000_0000, 32'h1234_5678, ok);
    if (m_acc[0] + m_inc[0] < MOD) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({ce, locked, cfg_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL rstpend_state: ce=%b locked=%b ready=%b, required 000 0 1", ce, locked, cfg_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (ce[0] !== ((k % 2) == 0) || cfg_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rstpend_no_apply edge %0d: ce0=%b ready=%b required %b 1", k, ce[0],
                 cfg_ready, (k % 2) == 0);
      end
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL rstpend_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
  endtask

  task automatic test_random();
    bit acc_now;
    for (int n = 0; n < 3000; n++) begin
      if (!cfg_valid && $urandom_range(0, 9) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_phase = $urandom;
        case ($urandom_range(0, 5))
          0:       cfg_inc = 32'h0;
          1:       cfg_inc = 32'h8000_0000;
          2:       cfg_inc = 32'hFFFF_FFFF;
          3:       cfg_inc = 32'h4000_0000;
          default: cfg_inc = $urandom_range(32'h0100_0000, 32'hFFFF_FFFF);
        endcase
      end
      rst_n   = ($urandom_range(0, 499) != 0);
      acc_now = cfg_valid && cfg_ready;
      tick();
      if (acc_now) cfg_valid = 1'b0;
      vectors++;
      if ({ce, locked, cfg_ready} !== {m_ce, m_locked, ~m_pend}) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d: ce=%b/%b locked=%b/%b ready=%b/%b", cyc,
                 ce, m_ce, locked, m_locked, cfg_ready, ~m_pend);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fractional();
    test_boundary();
    test_inactive();
    test_handshake();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frac_clken_gen.md
FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent clock-enable channels, 1..8.
REQ-002 Parameter ACC_W, default 32: phase accumulator and increment width, 8..32.
REQ-003 Parameter LOCK_PULSES, default 4: number of ce pulses per active channel required before locked asserts, 1..255.
REQ-004 Parameter INC_RST, default {CHANNELS{2^(ACC_W-1)}}: packed CHANNELS*ACC_W reset increments, channel 0 in the LSBs.
REQ-005 clk_sys  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 cfg_valid  in  1  a configuration request is present.
REQ-008 cfg_ready  out  1  the block can accept a request.
REQ-009 cfg_ch  in  max(1,clog2(CHANNELS))  target channel.
REQ-010 cfg_inc  in  ACC_W  new increment; 0 disables the channel.
REQ-011 cfg_phase  in  ACC_W  accumulator start value applied with the new increment.
REQ-012 ce  out  CHANNELS  registered one-cycle clock-enable pulses, one bit per channel.
REQ-013 locked  out  1  all active channels are running at the configured rate.

Function
REQ-014 Each channel i SHALL hold acc[i] and inc[i]; every cycle: acc[i] <= (acc[i]+inc[i]) mod 2^ACC_W, and ce[i] <= carry-out of that addition.
REQ-015 ce average rate SHALL be f_clk_sys*inc/2^ACC_W; no two consecutive ce cycles unless inc >= 2^(ACC_W-1); inc = 2^ACC_W-1 yields ce high every cycle except one per 2^ACC_W cycles.
REQ-016 inc[i]=0 SHALL hold acc[i] and force ce[i]=0; such a channel is inactive.
REQ-017 Handshake: a request transfers on a cycle with cfg_valid=1 and cfg_ready=1; fields are captured into a single shadow register {ch, inc, phase} plus a pending flag.
REQ-018 cfg_ready SHALL equal NOT pending; at most one request is outstanding at a time.
REQ-019 Pending, target channel active: the shadow SHALL be applied in the cycle in which that channel's addition produces a carry (ce[ch] <= 1 that cycle); in that cycle acc <= shadow phase and inc <= shadow inc, so no pulse is lost or duplicated at the boundary.
REQ-020 Pending, target channel inactive: the shadow SHALL be applied on the cycle after acceptance; ce[ch] stays 0 that cycle.
REQ-021 Pending SHALL clear in the apply cycle, so cfg_ready = 1 on the following cycle; a new request may be accepted then.
REQ-022 cfg_ch >= CHANNELS SHALL be accepted and discarded: pending is not set and no state changes.
REQ-023 Each channel SHALL keep a saturating pulse counter (8 bit) that counts ce pulses and clears on reset or on an apply to that channel.
REQ-024 locked SHALL be registered: 1 when no request is pending, at least one channel is active, and every active channel's counter >= LOCK_PULSES; otherwise 0.
REQ-025 locked SHALL drop to 0 on the cycle after any request is accepted and SHALL stay 0 until the condition in REQ-024 holds again.
REQ-026 Other channels SHALL be unaffected by a configuration apply (no phase disturbance).

Reset
REQ-027 While rst_n=0 at a clock edge: acc[i]=0, inc[i]=INC_RST slice i, ce=0, locked=0, pending=0, cfg_ready=1, counters=0.
REQ-028 A reset asserted mid-pending SHALL discard the shadow; no apply occurs after release.
REQ-029 The first accumulation SHALL occur on the first edge at which rst_n=1.

Verification
REQ-030 Defaults (ACC_W=32, inc=0x80000000): release rst_n -> ce[0] = 0,1,0,1... starting on the 2nd edge after release; locked=1 after the 4th pulse of all 3 channels.
REQ-031 Fractional: cfg ch1 inc=0x2AAAAAAB, phase=0 -> exactly 1 ce per 6 cycles averaged over 6000 cycles (1000 pulses, ±1); locked drops the cycle after acceptance and returns after 4 pulses.
REQ-032 Boundary apply: ch0 at inc=0x40000000, request inc=0x80000000 phase=0x80000000 -> last old-rate pulse occurs, the next pulse follows 1 cycle later, then 1 every 2 cycles; ch1/ch2 pulse timing unchanged.
REQ-033 Inactive: cfg ch2 inc=0 -> ce[2] stays 0, locked re-asserts based on ch0/ch1 only; then cfg ch2 inc=0x80000000 phase=0 -> applied 1 cycle after acceptance, cfg_ready=1 the cycle after that.
REQ-034 Handshake: hold cfg_valid=1 with cfg_ready=0 for 10 cycles -> no second capture; cfg_ch=3 with CHANNELS=3 -> discarded, cfg_ready stays 1.
REQ-035 Reset mid-pending: accept a request for ch0, pull rst_n low 1 cycle before ch0 carries -> after release inc[0]=INC_RST, pending=0, no apply.
